// File: rtl/matrix_reader_pkg.sv
// Shared types and width helpers for the matrix reader and its stream buffer.
package matrix_reader_pkg;

    // Pass sequencing: wait, issue reads, let the buffer run dry, signal completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Output buffer depth; also the number of read credits.
    localparam int BUF_DEPTH = 2;

    // Address width for an n x n matrix, never narrower than one bit.
    function automatic int aw_of(input int dim);
        return (dim * dim > 1) ? $clog2(dim * dim) : 1;
    endfunction

    // Row/column index width for an n x n matrix, never narrower than one bit.
    function automatic int iw_of(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO. Entry 0 is always the head, so the output is a
// plain register with no read mux. Simultaneous push and pop keep occupancy.
module stream_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next-state of the two slots: pops shift slot 1 forward, pushes fill the
    // first free slot counted after any same-cycle pop.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = push_data_i;
                end else begin
                    slot1_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = push_data_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/matrix_reader.sv
// Walks an n x n matrix row-major out of a synchronous RAM and streams each
// element with its (i, j) indices over valid/ready, pulsing done at the end.
//
// Handshake: a beat transfers on a cycle where out_valid && out_ready. Once
// out_valid is high it stays high, and out_data/out_i/out_j/out_last stay
// stable, until that transfer happens.
module matrix_reader
    import matrix_reader_pkg::*;
#(
    parameter int n      = 8,
    parameter int DATA_W = 32,
    localparam int AW    = aw_of(n),
    localparam int IW    = iw_of(n)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic [IW-1:0]     out_i,
    output logic [IW-1:0]     out_j,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output state_e            dbg_state
);

    localparam int            EW       = DATA_W + 2 * IW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(n - 1);

    state_e          state_q;
    logic [IW-1:0]   i_q;
    logic [IW-1:0]   j_q;
    logic [AW-1:0]   addr_q;
    logic            busy_q;
    logic            done_q;
    logic            last_seen_q;

    logic            rd_pend_q;
    logic [IW-1:0]   rd_i_q;
    logic [IW-1:0]   rd_j_q;
    logic            rd_last_q;

    logic [EW-1:0]   push_entry;
    logic [EW-1:0]   fifo_head;
    logic [1:0]      fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    logic            pop;
    logic [2:0]      credit_used;
    logic            issue;
    logic            issue_last;

    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign issue_last = (i_q == LAST_IDX) && (j_q == LAST_IDX);

    // A slot freed by a same-cycle pop counts as available, which is what lets
    // the stream sustain one beat per cycle with only two buffer entries.
    assign credit_used = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, rd_pend_q};
    assign issue       = (state_q == ISSUE) && (credit_used < 3'(BUF_DEPTH));

    // Tag each read with its indices so data and position arrive together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rd_i_q    <= '0;
            rd_j_q    <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_pend_q <= issue;
            if (issue) begin
                rd_i_q    <= i_q;
                rd_j_q    <= j_q;
                rd_last_q <= issue_last;
            end
        end
    end

    assign push_entry = {rd_last_q, rd_i_q, rd_j_q, rd_data};

    stream_fifo2 #(
        .W (EW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rd_pend_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Pass sequencer with the issue counters and the registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop && out_last) begin
                last_seen_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= ISSUE;
                        busy_q      <= 1'b1;
                        i_q         <= '0;
                        j_q         <= '0;
                        addr_q      <= '0;
                        last_seen_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_q <= addr_q + 1'b1;
                        if (j_q == LAST_IDX) begin
                            j_q <= '0;
                            i_q <= i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                        if (issue_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !rd_pend_q && last_seen_q) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The credit scheme must never push into a full buffer without a pop.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_pend_q && fifo_full && !pop));

    assign rd_en     = issue;
    assign rd_addr   = addr_q;
    assign out_data  = fifo_head[DATA_W-1:0];
    assign out_j     = fifo_head[DATA_W +: IW];
    assign out_i     = fifo_head[DATA_W + IW +: IW];
    assign out_last  = fifo_head[EW-1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_reader.sv
// Bench for matrix_reader: an n=8 instance against a queue-based pass model,
// plus a directed n=1 instance.
module tb_matrix_reader;

    localparam int N8  = 8;
    localparam int DW  = 32;
    localparam int NE  = N8 * N8;
    localparam int EW8 = 1 + 3 + 3 + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- n = 8 instance ----------------
    logic          start8, busy8, rd_en8, out_last8, out_valid8, out_ready8, done8;
    logic [5:0]    rd_addr8;
    logic [DW-1:0] rd_data8, out_data8;
    logic [2:0]    out_i8, out_j8;
    matrix_reader_pkg::state_e dbg8;

    matrix_reader #(.n(N8), .DATA_W(DW)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8),
        .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8),
        .out_data(out_data8), .out_i(out_i8), .out_j(out_j8),
        .out_last(out_last8), .out_valid(out_valid8), .out_ready(out_ready8),
        .done(done8), .dbg_state(dbg8)
    );

    logic [DW-1:0] ram8 [NE];
    always @(posedge clk) rd_data8 <= rd_en8 ? ram8[rd_addr8] : $urandom;

    // ---------------- n = 1 instance ----------------
    logic          start1, busy1, rd_en1, out_last1, out_valid1, out_ready1, done1;
    logic [0:0]    rd_addr1, out_i1, out_j1;
    logic [DW-1:0] rd_data1, out_data1;
    logic [DW-1:0] ram1;
    matrix_reader_pkg::state_e dbg1;

    matrix_reader #(.n(1), .DATA_W(DW)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_data(out_data1), .out_i(out_i1), .out_j(out_j1),
        .out_last(out_last1), .out_valid(out_valid1), .out_ready(out_ready1),
        .done(done1), .dbg_state(dbg1)
    );

    always @(posedge clk) rd_data1 <= rd_en1 ? ram1 : $urandom;

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural pass model (n = 8) ----------------
    logic [EW8-1:0] exp_q[$];
    bit   active      = 0;
    bit   valid_seen  = 0;
    int   start_cyc   = 0;
    int   done_cyc    = -1;
    int   reads       = 0;
    int   beats       = 0;
    int   passes_done = 0;
    int   first_valid_cyc, first_hs_cyc, last_hs_cyc, done_seen_cyc;
    logic [DW-1:0] hs_data [NE];
    logic [2:0]    hs_i    [NE];
    logic [2:0]    hs_j    [NE];
    logic          hs_last [NE];

    // Compare process: outputs sampled mid-cycle, model advanced afterwards.
    always @(negedge clk) begin
        int  c;
        bit  hs;
        c = cyc;
        if (!rst_n) begin
            chk("reset_outputs_zero",
                {busy8, rd_en8, rd_addr8, out_data8, out_i8, out_j8, out_last8, out_valid8, done8}, 64'd0);
            exp_q.delete();
            active   = 0;
            done_cyc = -1;
            reads    = 0;
            beats    = 0;
        end else begin
            chk("busy", busy8, active && (c != done_cyc));
            chk("done", done8, active && (c == done_cyc));
            if (done8) done_seen_cyc = c;
            hs = out_valid8 && out_ready8;
            if (out_valid8) begin
                if (active && !valid_seen) begin
                    chk("first_valid_latency", 64'(c - start_cyc), 64'd3);
                    valid_seen      = 1;
                    first_valid_cyc = c;
                end
                if (exp_q.size() == 0) chk("valid_without_pending_beat", 1'b1, 1'b0);
                else chk("beat_last_i_j_data", {out_last8, out_i8, out_j8, out_data8}, exp_q[0]);
            end
            if (hs && exp_q.size() > 0) begin
                if (beats == 0) first_hs_cyc = c;
                last_hs_cyc    = c;
                hs_data[beats] = out_data8;
                hs_i[beats]    = out_i8;
                hs_j[beats]    = out_j8;
                hs_last[beats] = out_last8;
                if (exp_q[0][EW8-1]) done_cyc = c + 2;
                void'(exp_q.pop_front());
                beats++;
            end
            if (rd_en8) begin
                chk("rd_en_inside_pass", active && reads < NE, 1'b1);
                chk("rd_addr", rd_addr8, 64'(reads));
                reads++;
                chk("read_credit", reads <= beats + 2, 1'b1);
            end
            if (active && c == done_cyc) begin
                chk("reads_per_pass", 64'(reads), 64'(NE));
                chk("beats_left_at_done", 64'(exp_q.size()), 64'd0);
                active   = 0;
                done_cyc = -1;
                passes_done++;
            end else if (!active && start8) begin
                exp_q.delete();
                for (int k = 0; k < NE; k++)
                    exp_q.push_back({k == NE - 1, 3'(k / N8), 3'(k % N8), ram8[k]});
                active     = 1;
                valid_seen = 0;
                start_cyc  = c;
                reads      = 0;
                beats      = 0;
            end
        end
    end

    // ---------------- driver ----------------
    // mode 0: ready high, 1: ready low for cycles 10..20, 2: ready 30% random,
    // 3: extra starts at beat 20 and in the done cycle, 4: reset at beat 30.
    task automatic run_pass(input int mode);
        int p0, s;
        bit fired, finished;
        p0 = passes_done; fired = 0; finished = 0;
        start8 = 1'b1;
        s = cyc;
        tick();
        start8 = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            case (mode)
                1:       out_ready8 = !(cyc >= s + 10 && cyc <= s + 20);
                2:       out_ready8 = ($urandom_range(0, 99) < 30);
                default: out_ready8 = 1'b1;
            endcase
            if (mode == 3) begin
                start8 = 1'b0;
                if (!fired && beats >= 20) begin start8 = 1'b1; fired = 1; end
                if (cyc == done_cyc) start8 = 1'b1;
            end
            if (mode == 4 && beats >= 30) begin
                rst_n = 1'b0;
                repeat (3) tick();
                rst_n = 1'b1;
                tick();
                finished = 1;
                break;
            end
            if (passes_done != p0) begin finished = 1; break; end
            tick();
        end
        start8     = 1'b0;
        out_ready8 = 1'b1;
        chk("pass_finished_in_budget", finished, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p;
        rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0; out_ready8 = 1'b1; out_ready1 = 1'b1;
        for (int k = 0; k < NE; k++) ram8[k] = DW'(k);
        ram1 = 32'hDEADBEEF;
        repeat (3) tick();
        chk("n1_reset_outputs_zero",
            {busy1, rd_en1, rd_addr1, out_data1, out_i1, out_j1, out_last1, out_valid1, done1}, 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Streaming pass, ready held high.
        run_pass(0);
        chk("pin_first_valid_cycle", 64'(first_valid_cyc - start_cyc), 64'd3);
        chk("pin_no_gaps", 64'(last_hs_cyc - first_hs_cyc), 64'd63);
        chk("pin_done_after_last", 64'(done_seen_cyc - last_hs_cyc), 64'd2);
        chk("pin_beat10_data", hs_data[10], 64'd10);
        chk("pin_beat10_ij", {hs_i[10], hs_j[10]}, {3'd1, 3'd2});
        chk("pin_beat62_not_last", hs_last[62], 1'b0);
        chk("pin_beat63", {hs_last[63], hs_i[63], hs_j[63], hs_data[63]}, {1'b1, 3'd7, 3'd7, 32'd63});
        repeat (3) tick();

        // Stall window.
        run_pass(1);
        chk("pin_stall_beat63_data", hs_data[63], 64'd63);
        repeat (2) tick();

        // Random backpressure over random contents.
        for (int k = 0; k < NE; k++) ram8[k] = $urandom;
        run_pass(2);
        repeat (2) tick();

        // Restarts while busy and in the done cycle are ignored.
        for (int k = 0; k < NE; k++) ram8[k] = DW'(k);
        p = passes_done;
        run_pass(3);
        repeat (10) tick();
        chk("single_pass_after_extra_starts", 64'(passes_done - p), 64'd1);

        // Abort by reset, then a fresh pass from (0,0).
        p = passes_done;
        run_pass(4);
        repeat (2) tick();
        chk("no_done_for_aborted_pass", 64'(passes_done - p), 64'd0);
        run_pass(0);
        chk("pin_restart_beat0", {hs_i[0], hs_j[0], hs_data[0]}, 64'd0);
        repeat (2) tick();

        // n = 1: a single beat.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_read_issued", {busy1, rd_en1, rd_addr1}, {1'b1, 1'b1, 1'b0});
        tick();
        chk("n1_single_read", {rd_en1, out_valid1}, 2'b00);
        tick();
        chk("n1_beat", {out_valid1, out_last1, out_i1, out_j1, out_data1},
            {1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF});
        tick();
        chk("n1_after_beat", {out_valid1, done1, busy1}, 3'b001);
        tick();
        chk("n1_done", {done1, busy1}, 2'b10);
        tick();
        chk("n1_done_one_cycle", {done1, busy1}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
